// File: rtl/vpu_seq_ctrl.sv
// vpu_seq_ctrl: accepts one vector instruction over the vpu_start/vpu_rdy
// handshake and sequences it element by element through VRF read, ALU execute
// and VRF write-back. vpu_rdy stays low (stalling the CPU) for the whole op.
module vpu_seq_ctrl #(
    parameter int unsigned NUM_ELEM = 4,
    parameter int unsigned ELEM_AW  = 2,
    parameter int unsigned VREG_AW  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vpu_start,
    input  logic [4:0]                 opcode,
    input  logic [VREG_AW-1:0]         vd,
    input  logic [VREG_AW-1:0]         vs,
    input  logic [VREG_AW-1:0]         vt,
    output logic                       vpu_rdy,
    output logic                       vrf_re,
    output logic [VREG_AW+ELEM_AW-1:0] vrf_ra_a,
    output logic [VREG_AW+ELEM_AW-1:0] vrf_ra_b,
    output logic                       vrf_we,
    output logic [VREG_AW+ELEM_AW-1:0] vrf_wa,
    output logic [2:0]                 alu_op,
    output logic                       alu_go,
    input  logic                       alu_valid,
    output logic                       op_err
);

    localparam int unsigned    AW       = VREG_AW + ELEM_AW;
    localparam logic [ELEM_AW-1:0] LAST_IDX = ELEM_AW'(NUM_ELEM - 1);
    localparam logic [ELEM_AW-1:0] IDX_ONE  = ELEM_AW'(1);
    localparam logic [ELEM_AW-1:0] IDX_ZERO = ELEM_AW'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t               state;
    logic [ELEM_AW-1:0]   idx;
    logic [VREG_AW-1:0]   vd_q;
    logic [VREG_AW-1:0]   vs_q;
    logic [VREG_AW-1:0]   vt_q;

    // Legal opcodes are the 5'b10xxx block.
    logic legal_c;
    assign legal_c = (opcode[4:3] == 2'b10);

    // Sequencer FSM; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= IDX_ZERO;
            vd_q     <= '0;
            vs_q     <= '0;
            vt_q     <= '0;
            vpu_rdy  <= 1'b1;
            vrf_re   <= 1'b0;
            vrf_ra_a <= AW'(0);
            vrf_ra_b <= AW'(0);
            vrf_we   <= 1'b0;
            vrf_wa   <= AW'(0);
            alu_op   <= 3'b000;
            alu_go   <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            vrf_re <= 1'b0;
            vrf_we <= 1'b0;
            alu_go <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vpu_start) begin
                        vd_q    <= vd;
                        vs_q    <= vs;
                        vt_q    <= vt;
                        alu_op  <= opcode[2:0];
                        idx     <= IDX_ZERO;
                        vpu_rdy <= 1'b0;
                        if (legal_c) begin
                            state    <= S_READ;
                            vrf_re   <= 1'b1;
                            vrf_ra_a <= {vs, IDX_ZERO};
                            vrf_ra_b <= {vt, IDX_ZERO};
                        end else begin
                            state  <= S_ERR;
                            op_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state  <= S_EXEC;
                    alu_go <= 1'b1;
                end
                S_EXEC: begin
                    // alu_go is high only in the first EXEC cycle, where alu_valid is ignored.
                    if (!alu_go && alu_valid) begin
                        state  <= S_WRITE;
                        vrf_we <= 1'b1;
                        vrf_wa <= {vd_q, idx};
                    end
                end
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state   <= S_IDLE;
                        idx     <= IDX_ZERO;
                        vpu_rdy <= 1'b1;
                    end else begin
                        state    <= S_READ;
                        idx      <= idx + IDX_ONE;
                        vrf_re   <= 1'b1;
                        vrf_ra_a <= {vs_q, idx + IDX_ONE};
                        vrf_ra_b <= {vt_q, idx + IDX_ONE};
                    end
                end
                S_ERR: begin
                    state   <= S_IDLE;
                    vpu_rdy <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    vpu_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Self-checking bench for vpu_seq_ctrl: table of whole vector ops plus
// hand-written back-to-back and mid-operation reset sequences.
module tb_vpu_seq_ctrl;

    localparam int unsigned NUM_ELEM = 4;
    localparam int unsigned ELEM_AW  = 2;
    localparam int unsigned VREG_AW  = 3;
    localparam int unsigned AW       = VREG_AW + ELEM_AW;

    logic               clk;
    logic               rst_n;
    logic               vpu_start;
    logic [4:0]         opcode;
    logic [VREG_AW-1:0] vd;
    logic [VREG_AW-1:0] vs;
    logic [VREG_AW-1:0] vt;
    logic               vpu_rdy;
    logic               vrf_re;
    logic [AW-1:0]      vrf_ra_a;
    logic [AW-1:0]      vrf_ra_b;
    logic               vrf_we;
    logic [AW-1:0]      vrf_wa;
    logic [2:0]         alu_op;
    logic               alu_go;
    logic               alu_valid;
    logic               op_err;

    vpu_seq_ctrl #(
        .NUM_ELEM(NUM_ELEM),
        .ELEM_AW (ELEM_AW),
        .VREG_AW (VREG_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vpu_start(vpu_start),
        .opcode   (opcode),
        .vd       (vd),
        .vs       (vs),
        .vt       (vt),
        .vpu_rdy  (vpu_rdy),
        .vrf_re   (vrf_re),
        .vrf_ra_a (vrf_ra_a),
        .vrf_ra_b (vrf_ra_b),
        .vrf_we   (vrf_we),
        .vrf_wa   (vrf_wa),
        .alu_op   (alu_op),
        .alu_go   (alu_go),
        .alu_valid(alu_valid),
        .op_err   (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed VRF traffic, recorded mid-cycle.
    int wr_addr[$];
    int wr_cyc[$];
    int rd_pair[$];
    int go_cnt = 0;
    always @(negedge clk) begin
        if (vrf_we) begin
            wr_addr.push_back(int'(vrf_wa));
            wr_cyc.push_back(cyc);
        end
        if (vrf_re) rd_pair.push_back(int'({vrf_ra_a, vrf_ra_b}));
        if (alu_go) go_cnt = go_cnt + 1;
    end

    // ALU model: latency 1, except slow_l for element slow_e of each op.
    int slow_e = 99;
    int slow_l = 1;
    initial begin
        int elem;
        int lat;
        alu_valid = 1'b0;
        elem = 0;
        forever begin
            @(negedge clk);
            if (vpu_rdy) elem = 0;
            if (alu_go) begin
                lat  = (elem == slow_e) ? slow_l : 1;
                elem = elem + 1;
                repeat (lat) @(posedge clk);
                #1 alu_valid = 1'b1;
                @(posedge clk);
                #1 alu_valid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issue one op from a negedge with vpu_rdy high; count busy cycles until idle again.
    task automatic run_op(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s,
                          input logic [2:0] t, output int a, output int busy);
        @(negedge clk);
        opcode    = op;
        vd        = d;
        vs        = s;
        vt        = t;
        vpu_start = 1'b1;
        a         = cyc + 1;
        @(posedge clk);
        #1 vpu_start = 1'b0;
        busy = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (vpu_rdy) break;
            busy = busy + 1;
        end
    endtask

    typedef struct {
        logic [4:0] opcode;
        logic [2:0] vd;
        logic [2:0] vs;
        logic [2:0] vt;
        int         slow_e;
        int         slow_l;
        int         exp_busy;
        int         exp_wr;
        int         exp_err;
        int         exp_aluop;
    } vec_t;

    vec_t tab[6];

    initial begin
        int a, a2, busy, busy2, w0, r0, g0, cum, lat, seen;

        tab[0] = '{5'b10001, 3'd2, 3'd3, 3'd4, 99, 1, 16, 4, 0, 1};
        tab[1] = '{5'b10110, 3'd5, 3'd5, 3'd1,  2, 5, 20, 4, 0, 6};
        tab[2] = '{5'b11000, 3'd1, 3'd2, 3'd3, 99, 1,  1, 0, 1, 0};
        tab[3] = '{5'b10111, 3'd7, 3'd0, 3'd7, 99, 1, 16, 4, 1, 7};
        tab[4] = '{5'b00101, 3'd3, 3'd3, 3'd3, 99, 1,  1, 0, 1, 5};
        tab[5] = '{5'b10000, 3'd0, 3'd1, 3'd2,  0, 2, 17, 4, 1, 0};

        rst_n     = 1'b0;
        vpu_start = 1'b0;
        opcode    = 5'd0;
        vd        = '0;
        vs        = '0;
        vt        = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",    int'(vpu_rdy), 1);
        chk("rst_err",    int'(op_err),  0);
        chk("rst_we",     int'(vrf_we),  0);
        chk("rst_go",     int'(alu_go),  0);
        chk("rst_re",     int'(vrf_re),  0);
        chk("rst_wa",     int'(vrf_wa),  0);
        chk("rst_alu_op", int'(alu_op),  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of whole operations.
        for (int n = 0; n < 6; n++) begin
            slow_e = tab[n].slow_e;
            slow_l = tab[n].slow_l;
            w0 = wr_addr.size();
            r0 = rd_pair.size();
            g0 = go_cnt;
            run_op(tab[n].opcode, tab[n].vd, tab[n].vs, tab[n].vt, a, busy);
            @(negedge clk);
            chk($sformatf("v%0d_busy", n),   busy, tab[n].exp_busy);
            chk($sformatf("v%0d_nwr", n),    wr_addr.size() - w0, tab[n].exp_wr);
            chk($sformatf("v%0d_nrd", n),    rd_pair.size() - r0, tab[n].exp_wr);
            chk($sformatf("v%0d_ngo", n),    go_cnt - g0, tab[n].exp_wr);
            chk($sformatf("v%0d_err", n),    int'(op_err), tab[n].exp_err);
            chk($sformatf("v%0d_alu_op", n), int'(alu_op), tab[n].exp_aluop);
            chk($sformatf("v%0d_rdy", n),    int'(vpu_rdy), 1);
            cum = 0;
            for (int i = 0; i < tab[n].exp_wr; i++) begin
                lat = (i == tab[n].slow_e) ? tab[n].slow_l : 1;
                cum = cum + 3 + lat;
                if (w0 + i < wr_addr.size()) begin
                    chk($sformatf("v%0d_wa%0d", n, i), wr_addr[w0 + i], int'(tab[n].vd) * 4 + i);
                    chk($sformatf("v%0d_wcyc%0d", n, i), wr_cyc[w0 + i] - a, cum - 1);
                end
                if (r0 + i < rd_pair.size())
                    chk($sformatf("v%0d_ra%0d", n, i), rd_pair[r0 + i],
                        ((int'(tab[n].vs) * 4 + i) << 5) | (int'(tab[n].vt) * 4 + i));
            end
        end

        // Second op held on vpu_start during a busy op: one accept on the first idle cycle.
        slow_e = 99;
        slow_l = 1;
        w0 = wr_addr.size();
        @(negedge clk);
        opcode    = 5'b10010;
        vd        = 3'd1;
        vs        = 3'd2;
        vt        = 3'd3;
        vpu_start = 1'b1;
        a         = cyc + 1;
        @(posedge clk);
        #1;
        opcode = 5'b10011;
        vd     = 3'd6;
        vs     = 3'd4;
        vt     = 3'd5;
        busy = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (vpu_rdy) break;
            busy = busy + 1;
        end
        a2 = cyc + 1;
        @(posedge clk);
        #1 vpu_start = 1'b0;
        busy2 = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (vpu_rdy) break;
            busy2 = busy2 + 1;
        end
        repeat (6) @(negedge clk);
        chk("b2b_busy1", busy, 16);
        chk("b2b_busy2", busy2, 16);
        chk("b2b_accept_gap", a2 - a, 17);
        chk("b2b_nwr", wr_addr.size() - w0, 8);
        chk("b2b_alu_op", int'(alu_op), 3);
        for (int i = 0; i < 8; i++) begin
            if (w0 + i < wr_addr.size()) begin
                chk($sformatf("b2b_wa%0d", i), wr_addr[w0 + i], (i < 4) ? (4 + i) : (24 + i - 4));
                chk($sformatf("b2b_wcyc%0d", i), wr_cyc[w0 + i] - a,
                    (i < 4) ? (3 + 4 * i) : (17 + 3 + 4 * (i - 4)));
            end
        end

        // Reset during the first EXEC cycle of element 1 aborts the op and clears op_err.
        slow_e = 1;
        slow_l = 3;
        w0 = wr_addr.size();
        chk("pre_rst_err", int'(op_err), 1);
        @(negedge clk);
        opcode    = 5'b10100;
        vd        = 3'd4;
        vs        = 3'd6;
        vt        = 3'd7;
        vpu_start = 1'b1;
        @(posedge clk);
        #1 vpu_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (alu_go) seen = seen + 1;
            if (seen == 2) break;
        end
        chk("mid_rst_reached_exec1", seen, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", int'(vpu_rdy), 1);
        chk("mid_rst_err", int'(op_err), 0);
        chk("mid_rst_we",  int'(vrf_we), 0);
        chk("mid_rst_nwr_before", wr_addr.size() - w0, 1);
        repeat (20) @(negedge clk);
        chk("mid_rst_nwr_after", wr_addr.size() - w0, 1);
        chk("mid_rst_rdy_after", int'(vpu_rdy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
